cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Transmit side of the common data bus (CDB). Collects completed results from
//  NUM_FU functional units, buffers each unit's results in a small FIFO, and
//  grants one result per cycle round-robin. The granted result is driven,
//  registered, onto the CDB broadcast inputs (v/robid/data) feeding the cdb stage.
//  The block sits between the FU writeback ports and the cdb register stage.
// PARAMETERS
//  NUM_FU     4   number of functional-unit result ports (2..8)
//  BUF_DEPTH  2   per-FU FIFO entries (power of 2, >=2)
// PORTS
//  clk           in   1                         core clock
//  rst_n         in   1                         async active-low reset
//  flush         in   1                         pipeline flush: drop all buffered results
//  fu_v          in   NUM_FU                    per-FU result valid (push)
//  fu_robid      in   NUM_FU x ROB_SIZE_CLOG    per-FU result ROB id
//  fu_data       in   NUM_FU x DATA_LEN         per-FU result data
//  fu_rdy        out  NUM_FU                    per-FU FIFO not full (may push)
//  cdb_v         out  1                         CDB broadcast valid
//  cdb_robid     out  ROB_SIZE_CLOG             CDB broadcast ROB id
//  cdb_data      out  DATA_LEN                  CDB broadcast data
//  stall_cnt     out  32                        only with CDB_ARB_STALL_CNT_EN
// BEHAVIOUR
//  - Reset (async on rst_n low): all FIFOs empty, fu_rdy = all 1s, cdb_v = 0,
//    cdb_robid = 0, cdb_data = 0, RR pointer = 0, stall_cnt = 0.
//  - Push: FIFO i is written at the edge when fu_v[i] && fu_rdy[i].
//    fu_rdy[i] = !full[i] (registered state only; no same-cycle pop credit).
//    fu_v[i] && !fu_rdy[i] is illegal: entry dropped, assertion fires.
//  - Arbitration (combinational each cycle): candidate set = non-empty FIFOs;
//    search starts at RR pointer, wraps modulo NUM_FU; first non-empty wins.
//    Winner is popped at the edge; RR pointer <= winner+1 (mod NUM_FU).
//    No candidates: pointer holds, nothing popped.
//  - Output register: cdb_v <= any candidate; cdb_robid/cdb_data <= winner
//    head. When no candidate, cdb_v <= 0 and robid/data hold their last values.
//  - Latency: push at edge E -> cdb_v=1 with that result after edge E+1
//    (2 cycles FU-valid-to-broadcast when uncontended). Throughput 1/cycle.
//  - Ordering: per-FU FIFO order preserved; no ordering across FUs.
//  - Simultaneous push+pop on same FIFO: both happen; count unchanged.
//    Push into empty FIFO is not visible to arbitration until next cycle.
//  - Wrap-around: FIFO rd/wr pointers are clog2(BUF_DEPTH)+1 bits; full when
//    MSBs differ and low bits equal; empty when equal.
//  - flush (sync, highest priority): at the edge all FIFOs empty, cdb_v <= 0,
//    pushes in that cycle dropped, RR pointer <= 0. fu_rdy all 1s next cycle.
//  - Reset asserted mid-operation: immediate return to reset values; in-flight
//    results lost; no partial broadcast.
// CONFIGURATION
//  CDB_ARB_STALL_CNT_EN defined: stall_cnt port exists; increments (saturating
//   at 2^32-1) each cycle where any fu_v[i]=1 && fu_rdy[i]=0, or >1 FIFO non-empty
//   (a result waited); cleared by reset, not by flush.
//  Not defined: port and counter absent; no other behavioural difference.
// STRUCTURE
//  - ROB_SIZE_CLOG, DATA_LEN and a cdb_pkt_t {robid, data} typedef come from
//    the shared structs package; no new package constants.
//  - Sub-module cdb_fu_fifo (one per FU, generate loop): BUF_DEPTH x cdb_pkt_t,
//    push/pop/flush, full/empty, head output. Arbiter + output reg in top.
// TESTING
//  1 Reset then FU1 push robid=5,data=0xDEAD -> cdb_v=1 robid=5 data=0xDEAD two
//    cycles later, cdb_v=0 the cycle after; fu_rdy stays 4'b1111.
//  2 All 4 FUs push once same cycle (robid 1..4), ptr=0 -> broadcasts robid
//    1,2,3,4 on 4 consecutive cycles, then cdb_v=0.
//  3 FU0 pushes every cycle, FU2 pushes every cycle -> CDB alternates FU0/FU2;
//    fu_rdy[0] drops to 0 when FIFO full (BUF_DEPTH=2), no result lost or dup.
//  4 Fill FU3 FIFO (2 entries), assert flush -> next cycle cdb_v=0, fu_rdy=1111,
//    no robid from before flush ever broadcast.
//  5 rst_n low mid-stream with 3 FIFOs non-empty -> outputs at reset values
//    immediately (async); after release, first push appears 2 cycles later.
//  6 With CDB_ARB_STALL_CNT_EN: test 2 -> stall_cnt = 3; flush leaves it unchanged.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB structs: ROB id width, result data width and the packet
// carried from a functional unit to the common data bus.
package cdb_arbiter_pkg;

  localparam int ROB_SIZE_CLOG = 6;
  localparam int DATA_LEN      = 32;

  typedef struct packed {
    logic [ROB_SIZE_CLOG-1:0] robid;
    logic [DATA_LEN-1:0]      data;
  } cdb_pkt_t;

endpackage

// File: rtl/cdb_fu_fifo.sv
// Per-FU result FIFO. Pointers carry one extra wrap bit so full and empty
// can be told apart without a separate counter. Flush empties the FIFO at
// the edge and wins over any push or pop in that cycle.
module cdb_fu_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  input  logic     push,
  input  logic     pop,
  input  cdb_pkt_t din,
  output logic     full,
  output logic     empty,
  output cdb_pkt_t head
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int PW = AW + 1;

  cdb_pkt_t        mem [BUF_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update: flush resets both pointers, otherwise advance on push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array needs no reset: contents are only read while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB transmit arbiter: one FIFO per functional unit, round-robin grant of
// one result per cycle, registered broadcast onto the CDB.
// Optional feature macro: CDB_ARB_STALL_CNT_EN adds a saturating stall counter.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU    = 4,
  parameter int BUF_DEPTH = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush,
  input  logic [NUM_FU-1:0]                   fu_v,
  input  logic [NUM_FU-1:0][ROB_SIZE_CLOG-1:0] fu_robid,
  input  logic [NUM_FU-1:0][DATA_LEN-1:0]     fu_data,
  output logic [NUM_FU-1:0]                   fu_rdy,
  output logic                                cdb_v,
  output logic [ROB_SIZE_CLOG-1:0]            cdb_robid,
  output logic [DATA_LEN-1:0]                 cdb_data
`ifdef CDB_ARB_STALL_CNT_EN
  ,
  output logic [31:0]                         stall_cnt
`endif
);

  localparam int PTR_W = $clog2(NUM_FU);

  logic [NUM_FU-1:0] full;
  logic [NUM_FU-1:0] empty;
  logic [NUM_FU-1:0] pop;
  cdb_pkt_t          din  [NUM_FU];
  cdb_pkt_t          head [NUM_FU];
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  win;
  logic [PTR_W-1:0]  next_ptr;
  logic              any_cand;

  assign fu_rdy = ~full;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
    assign din[i] = '{robid: fu_robid[i], data: fu_data[i]};
    assign pop[i] = any_cand && (win == PTR_W'(i));

    cdb_fu_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (fu_v[i]),
      .pop   (pop[i]),
      .din   (din[i]),
      .full  (full[i]),
      .empty (empty[i]),
      .head  (head[i])
    );
  end

  // Round-robin search: first non-empty FIFO at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    any_cand = 1'b0;
    win      = '0;
    idx      = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (!empty[idx] && !any_cand) begin
        any_cand = 1'b1;
        win      = idx[PTR_W-1:0];
      end
    end
  end

  assign next_ptr = (win == PTR_W'(NUM_FU - 1)) ? '0 : win + 1'b1;

  // Broadcast register and RR pointer; robid/data hold when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_v     <= 1'b0;
      cdb_robid <= '0;
      cdb_data  <= '0;
      rr_ptr    <= '0;
    end else if (flush) begin
      cdb_v  <= 1'b0;
      rr_ptr <= '0;
    end else begin
      cdb_v <= any_cand;
      if (any_cand) begin
        cdb_robid <= head[win].robid;
        cdb_data  <= head[win].data;
        rr_ptr    <= next_ptr;
      end
    end
  end

`ifdef CDB_ARB_STALL_CNT_EN
  logic stall_evt;
  assign stall_evt = (|(fu_v & ~fu_rdy)) || ($countones(~empty) > 1);

  // Saturating count of cycles where a result had to wait; flush does not clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_evt && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

  // A push into a full FIFO is a protocol error by the functional unit.
  assert property (@(posedge clk) disable iff (!rst_n) !(|(fu_v & ~fu_rdy)));

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NUM_FU    = 4;
  localparam int BUF_DEPTH = 2;

  logic                                 clk = 1'b0;
  logic                                 rst_n;
  logic                                 flush;
  logic [NUM_FU-1:0]                    fu_v;
  logic [NUM_FU-1:0][ROB_SIZE_CLOG-1:0] fu_robid;
  logic [NUM_FU-1:0][DATA_LEN-1:0]      fu_data;
  logic [NUM_FU-1:0]                    fu_rdy;
  logic                                 cdb_v;
  logic [ROB_SIZE_CLOG-1:0]             cdb_robid;
  logic [DATA_LEN-1:0]                  cdb_data;
`ifdef CDB_ARB_STALL_CNT_EN
  logic [31:0]                          stall_cnt;
`endif

  cdb_arbiter #(.NUM_FU(NUM_FU), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .fu_v      (fu_v),
    .fu_robid  (fu_robid),
    .fu_data   (fu_data),
    .fu_rdy    (fu_rdy),
    .cdb_v     (cdb_v),
    .cdb_robid (cdb_robid),
    .cdb_data  (cdb_data)
`ifdef CDB_ARB_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: one queue per FU, round-robin pointer, broadcast state.
  cdb_pkt_t                 mq [NUM_FU][$];
  int                       m_ptr;
  logic                     m_v;
  logic [ROB_SIZE_CLOG-1:0] m_robid;
  logic [DATA_LEN-1:0]      m_data;
  longint                   m_stall;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_FU; i++) mq[i].delete();
    m_ptr = 0; m_v = 1'b0; m_robid = '0; m_data = '0; m_stall = 0;
  endtask

  function automatic bit can_push(input int i);
    return mq[i].size() < BUF_DEPTH;
  endfunction

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_update();
    int  presz [NUM_FU];
    int  nonempty;
    bit  illegal;
    int  w;
    cdb_pkt_t pkt;
    if (!rst_n) return;
    nonempty = 0; illegal = 0;
    for (int i = 0; i < NUM_FU; i++) begin
      presz[i] = mq[i].size();
      if (presz[i] > 0) nonempty++;
      if (fu_v[i] && presz[i] >= BUF_DEPTH) illegal = 1;
    end
    if ((illegal || nonempty > 1) && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (flush) begin
      for (int i = 0; i < NUM_FU; i++) mq[i].delete();
      m_v = 1'b0; m_ptr = 0;
      return;
    end
    w = -1;
    for (int k = 0; k < NUM_FU; k++)
      if (w < 0 && presz[(m_ptr + k) % NUM_FU] > 0) w = (m_ptr + k) % NUM_FU;
    if (w >= 0) begin
      pkt = mq[w].pop_front();
      m_v = 1'b1; m_robid = pkt.robid; m_data = pkt.data;
      m_ptr = (w + 1) % NUM_FU;
    end else begin
      m_v = 1'b0;
    end
    for (int i = 0; i < NUM_FU; i++)
      if (fu_v[i] && presz[i] < BUF_DEPTH) mq[i].push_back('{robid: fu_robid[i], data: fu_data[i]});
  endtask

  task automatic check_output();
    for (int i = 0; i < NUM_FU; i++)
      check($sformatf("fu_rdy[%0d]", i), 64'(fu_rdy[i]), 64'(can_push(i)));
    check("cdb_v", 64'(cdb_v), 64'(m_v));
    check("cdb_robid", 64'(cdb_robid), 64'(m_robid));
    check("cdb_data", 64'(cdb_data), 64'(m_data));
`ifdef CDB_ARB_STALL_CNT_EN
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
  endtask

  // One clock: model follows the edge, DUT is sampled 1ns later, inputs cleared.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_output();
    fu_v  = '0;
    flush = 1'b0;
  endtask

  task automatic apply_stimulus(input int i, input logic [ROB_SIZE_CLOG-1:0] r,
                                input logic [DATA_LEN-1:0] d);
    if (can_push(i)) begin
      fu_v[i]     = 1'b1;
      fu_robid[i] = r;
      fu_data[i]  = d;
    end
  endtask

  task automatic sync_reset();
    rst_n = 1'b0;
    model_reset();
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    bit seen_full0;
    rst_n = 1'b0; flush = 1'b0; fu_v = '0; fu_robid = '0; fu_data = '0;
    model_reset();
    #2;
    check("reset cdb_v", 64'(cdb_v), 64'd0);
    check("reset fu_rdy", 64'(fu_rdy), 64'hF);
    sync_reset();

    // Single push from FU1: broadcast two edges later, then idle.
    $display("[TB] single push");
    apply_stimulus(1, 6'd5, 32'hDEAD);
    step();
    check("t1 cdb_v e0", 64'(cdb_v), 64'd0);
    step();
    check("t1 cdb_v e1", 64'(cdb_v), 64'd1);
    check("t1 robid", 64'(cdb_robid), 64'd5);
    check("t1 data", 64'(cdb_data), 64'hDEAD);
    step();
    check("t1 cdb_v e2", 64'(cdb_v), 64'd0);
    check("t1 fu_rdy", 64'(fu_rdy), 64'hF);

    // All four FUs at once, pointer at 0: robids come out in order 1..4.
    $display("[TB] four-way contention");
    sync_reset();
    for (int i = 0; i < NUM_FU; i++) apply_stimulus(i, 6'(i + 1), 32'(32'h100 + i));
    step();
    for (int k = 1; k <= NUM_FU; k++) begin
      step();
      check("t2 cdb_v", 64'(cdb_v), 64'd1);
      check("t2 robid order", 64'(cdb_robid), 64'(k));
    end
    step();
    check("t2 idle", 64'(cdb_v), 64'd0);
`ifdef CDB_ARB_STALL_CNT_EN
    check("t2 stall_cnt", 64'(stall_cnt), 64'd3);
    flush = 1'b1;
    step();
    check("t2 stall after flush", 64'(stall_cnt), 64'd3);
`endif

    // FU0 and FU2 stream continuously: backlog fills FU0's FIFO.
    $display("[TB] two streams");
    flush = 1'b1;
    step();
    seen_full0 = 0;
    for (int c = 0; c < 16; c++) begin
      apply_stimulus(0, 6'(c), 32'(32'hA000 + c));
      apply_stimulus(2, 6'(32 + c), 32'(32'hC000 + c));
      step();
      if (fu_rdy[0] == 1'b0) seen_full0 = 1;
    end
    check("t3 fu_rdy0 dropped", 64'(seen_full0), 64'd1);
    for (int c = 0; c < 6; c++) step();

    // Fill FU3, then flush: nothing buffered before the flush comes out.
    $display("[TB] flush");
    flush = 1'b1;
    step();
    for (int i = 0; i < NUM_FU; i++) apply_stimulus(i, 6'(40 + i), 32'(32'h4000 + i));
    step();
    apply_stimulus(3, 6'd44, 32'h4444);
    step();
    check("t4 robid before flush", 64'(cdb_robid), 64'd40);
    check("t4 fu_rdy full3", 64'(fu_rdy), 64'h7);
    flush = 1'b1;
    step();
    check("t4 cdb_v after flush", 64'(cdb_v), 64'd0);
    check("t4 fu_rdy after flush", 64'(fu_rdy), 64'hF);
    for (int c = 0; c < 4; c++) begin
      step();
      check("t4 no stale broadcast", 64'(cdb_v), 64'd0);
      check("t4 robid held", 64'(cdb_robid), 64'd40);
    end

    // Asynchronous reset mid-stream with three FIFOs holding data.
    $display("[TB] async reset");
    for (int i = 0; i < 3; i++) apply_stimulus(i, 6'(50 + i), 32'(32'h5000 + i));
    step();
    for (int i = 0; i < 3; i++) apply_stimulus(i, 6'(54 + i), 32'(32'h5400 + i));
    step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t5 cdb_v", 64'(cdb_v), 64'd0);
    check("t5 robid", 64'(cdb_robid), 64'd0);
    check("t5 data", 64'(cdb_data), 64'd0);
    check("t5 fu_rdy", 64'(fu_rdy), 64'hF);
    step();
    rst_n = 1'b1;
    apply_stimulus(2, 6'd7, 32'h77);
    step();
    check("t5 post e0", 64'(cdb_v), 64'd0);
    step();
    check("t5 post e1", 64'(cdb_v), 64'd1);
    check("t5 post robid", 64'(cdb_robid), 64'd7);

    // Randomised traffic with occasional flushes.
    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_FU; i++)
        if ($urandom_range(0, 99) < 55)
          apply_stimulus(i, 6'($urandom), $urandom);
      flush = ($urandom_range(0, 99) < 3);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
